// File: rtl/dice_pkg.sv
// Shared types and constants for the dice-roll scheduling blocks.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int FACE_W    = 3;
  localparam int NUM_FACES = 7;

  // Counter width able to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dice_roll_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr, cyclically.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic                    gnt_valid,
  output logic [$clog2(NREQ)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(NREQ);
  localparam logic [IDX_W:0] NREQ_V = (IDX_W + 1)'(NREQ);

  logic [IDX_W-1:0] cand [NREQ];
  logic [NREQ-1:0]  hit;

  // cand[gi] is the requester gi positions after the pointer.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    logic [IDX_W:0] sum;
    logic [IDX_W:0] wrapped;
    assign sum      = {1'b0, rr_ptr} + (IDX_W + 1)'(gi);
    assign wrapped  = (sum >= NREQ_V) ? (sum - NREQ_V) : sum;
    assign cand[gi] = wrapped[IDX_W-1:0];
    assign hit[gi]  = req[cand[gi]];
  end

  always_comb begin
    gnt_valid = |hit;
    gnt_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (hit[k]) gnt_idx = cand[k];
    end
  end

endmodule

// File: rtl/dice_roll_scheduler.sv
// Shares one dice between NREQ requesters: round-robin grant, fixed-latency
// roll sampling, bounded re-rolls on rejected rolls, one-cycle ack pulse.
module dice_roll_scheduler
  import dice_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DICE_LAT  = 3,
  parameter int MAX_RETRY = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   ack,
  output logic [FACE_W-1:0] rsp_face,
  output logic              rsp_err,
  output logic              busy,
  output logic              dice_req,
  input  logic              dice_valid_roll,
  input  logic [FACE_W-1:0] dice_face
);

  localparam int IDX_W   = $clog2(NREQ);
  localparam int LAT_W   = cnt_width(DICE_LAT);
  localparam int RETRY_W = cnt_width(MAX_RETRY);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic [FACE_W-1:0]   face_q, face_d;
  logic                err_q, err_d;

  logic                gnt_valid;
  logic [IDX_W-1:0]    gnt_idx;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    lat_d    = lat_q;
    retry_d  = retry_q;
    ack_d    = '0;
    face_d   = '0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt_idx;
          retry_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        lat_d   = LAT_W'(DICE_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q != '0) begin
          lat_d = lat_q - LAT_W'(1);
        end else if (dice_valid_roll) begin
          ack_d[owner_q] = 1'b1;
          face_d         = dice_face;
          state_d        = RESP;
        end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
          retry_d = retry_q + RETRY_W'(1);
          state_d = ISSUE;
        end else begin
          // Budget exhausted: report an error with a zero face.
          ack_d[owner_q] = 1'b1;
          err_d          = 1'b1;
          state_d        = RESP;
        end
      end
      RESP: begin
        rr_ptr_d = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + IDX_W'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      lat_q    <= '0;
      retry_q  <= '0;
      ack_q    <= '0;
      face_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      lat_q    <= lat_d;
      retry_q  <= retry_d;
      ack_q    <= ack_d;
      face_q   <= face_d;
      err_q    <= err_d;
    end
  end

  assign ack      = ack_q;
  assign rsp_face = face_q;
  assign rsp_err  = err_q;
  assign busy     = (state_q != IDLE);
  assign dice_req = (state_q == ISSUE);

endmodule

// File: tb/tb_dice_roll_scheduler.sv
// Bench for dice_roll_scheduler: scripted dice model, ack monitor, directed and random scenarios.
module tb_dice_roll_scheduler;

  localparam int NREQ      = 4;
  localparam int DICE_LAT  = 3;
  localparam int MAX_RETRY = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] ack;
  logic [2:0] rsp_face;
  logic       rsp_err;
  logic       busy;
  logic       dice_req;
  logic       dice_valid_roll;
  logic [2:0] dice_face;

  typedef struct packed {logic valid; logic [2:0] face;} roll_t;
  typedef struct {int due; roll_t r;} pend_t;
  typedef struct {int cyc; logic [3:0] ack; logic [2:0] face; logic err;} ack_rec_t;

  roll_t    script_q[$];
  pend_t    pend_q[$];
  ack_rec_t ack_q[$];
  int       grant_q[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int dreq_cnt = 0;
  int last_ack_cyc = -100;
  logic prev_busy = 1'b0;

  dice_roll_scheduler #(
    .NREQ      (NREQ),
    .DICE_LAT  (DICE_LAT),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req             (req),
    .ack             (ack),
    .rsp_face        (rsp_face),
    .rsp_err         (rsp_err),
    .busy            (busy),
    .dice_req        (dice_req),
    .dice_valid_roll (dice_valid_roll),
    .dice_face       (dice_face)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  function automatic roll_t mk_roll(input logic v, input logic [2:0] f);
    roll_t r;
    r.valid = v;
    r.face  = f;
    return r;
  endfunction

  // Cycles from the IDLE grant cycle to the ack cycle for a given roll count.
  function automatic int exp_lat(input int rolls);
    return rolls * (DICE_LAT + 1) + 1;
  endfunction

  // Dice model: each roll request gets the next scripted result, presented
  // exactly DICE_LAT cycles later; random junk is driven at all other times.
  initial begin
    pend_t p;
    dice_valid_roll = 1'b0;
    dice_face       = 3'd0;
    forever begin
      @(negedge clk);
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        dice_valid_roll = pend_q[0].r.valid;
        dice_face       = pend_q[0].r.face;
        pend_q.delete(0);
      end else begin
        dice_valid_roll = 1'($urandom);
        dice_face       = 3'($urandom);
      end
      if (rst_n && dice_req === 1'b1) begin
        dreq_cnt++;
        checks++;
        if (pend_q.size() != 0) begin
          failures++;
          $display("FAIL roll_overlap: dice_req with %0d roll(s) in flight, required 0", pend_q.size());
        end
        p.due = cyc + DICE_LAT;
        p.r   = (script_q.size() > 0) ? script_q.pop_front() : mk_roll(1'b1, 3'd0);
        pend_q.push_back(p);
      end
    end
  end

  // Ack / grant monitor with protocol invariants.
  initial begin
    ack_rec_t rec;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 1'b0;
      end else begin
        if (busy === 1'b1 && prev_busy === 1'b0) grant_q.push_back(cyc - 1);
        prev_busy = busy;
        if (dice_req === 1'b1 && busy !== 1'b1) begin
          failures++;
          $display("FAIL dice_req_idle: dice_req=1 busy=%b, required busy=1", busy);
        end
        if (ack !== 4'b0000) begin
          rec.cyc  = cyc;
          rec.ack  = ack;
          rec.face = rsp_face;
          rec.err  = rsp_err;
          ack_q.push_back(rec);
          checks++;
          if ($countones(ack) != 1) begin
            failures++;
            $display("FAIL ack_onehot: ack=%b, required one-hot", ack);
          end
          checks++;
          if (last_ack_cyc == cyc - 1) begin
            failures++;
            $display("FAIL ack_adjacent: ack in cycles %0d and %0d, required a gap", last_ack_cyc, cyc);
          end
          last_ack_cyc = cyc;
        end else if (rsp_face !== 3'd0 || rsp_err !== 1'b0) begin
          failures++;
          $display("FAIL rsp_idle: face=%0d err=%b with ack=0, required 0/0", rsp_face, rsp_err);
        end
      end
    end
  end

  task automatic flush_q();
    script_q.delete();
    pend_q.delete();
    ack_q.delete();
    grant_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req   = '0;
    repeat (3) @(posedge clk);
    flush_q();
    last_ack_cyc = -100;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input int max_cyc, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      #1;
      if (ack_q.size() > 0) begin
        found = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_grant(input int max_cyc, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      #1;
      if (grant_q.size() > 0) begin
        found = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    checks++;
    if ({ack, rsp_face, rsp_err, busy, dice_req} !== 10'd0) begin
      failures++;
      $display("FAIL reset_outputs: ack=%b face=%0d err=%b busy=%b dreq=%b, required all 0",
               ack, rsp_face, rsp_err, busy, dice_req);
    end
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ack, busy, dice_req} !== 6'd0) begin
      failures++;
      $display("FAIL idle_after_reset: ack=%b busy=%b dreq=%b, required 0", ack, busy, dice_req);
    end
  endtask

  task automatic test_single();
    bit found;
    ack_rec_t r;
    int g;
    flush_q();
    script_q.push_back(mk_roll(1'b1, 3'd5));
    dreq_cnt = 0;
    @(posedge clk);
    #1;
    req = 4'b0001;
    wait_ack(40, found);
    @(posedge clk);
    #1;
    req = '0;
    checks++;
    if (!found || grant_q.size() == 0) begin
      failures++;
      $display("FAIL single_timeout: ack seen=%0d grant seen=%0d, required 1/1", found, grant_q.size());
      return;
    end
    r = ack_q.pop_front();
    g = grant_q.pop_front();
    $display("txn single ack=%b face=%0d err=%0d lat=%0d", r.ack, r.face, r.err, r.cyc - g);
    checks++;
    if (r.ack !== 4'b0001 || r.face !== 3'd5 || r.err !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp: ack=%b face=%0d err=%b, required 0001/5/0", r.ack, r.face, r.err);
    end
    checks++;
    if (r.cyc - g != exp_lat(1)) begin
      failures++;
      $display("FAIL single_lat: %0d cycles, required %0d", r.cyc - g, exp_lat(1));
    end
    checks++;
    if (dreq_cnt != 1) begin
      failures++;
      $display("FAIL single_dreq: %0d pulses, required 1", dreq_cnt);
    end
  endtask

  task automatic test_round_robin();
    bit found;
    ack_rec_t r;
    logic [2:0] faces[5];
    int prev_cyc;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      faces[i] = 3'($urandom_range(0, 6));
      script_q.push_back(mk_roll(1'b1, faces[i]));
    end
    prev_cyc = 0;
    @(posedge clk);
    #1;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack(30, found);
      checks++;
      if (!found) begin
        failures++;
        $display("FAIL rr_timeout: ack %0d never seen, required within 30 cycles", i);
        req = '0;
        return;
      end
      r = ack_q.pop_front();
      $display("txn rr%0d ack=%b face=%0d err=%0d", i, r.ack, r.face, r.err);
      checks++;
      if (r.ack !== 4'(1 << (i % NREQ)) || r.face !== faces[i] || r.err !== 1'b0) begin
        failures++;
        $display("FAIL rr_order%0d: ack=%b face=%0d err=%b, required %b/%0d/0",
                 i, r.ack, r.face, r.err, 4'(1 << (i % NREQ)), faces[i]);
      end
      if (i > 0) begin
        checks++;
        if (r.cyc - prev_cyc != exp_lat(1) + 1) begin
          failures++;
          $display("FAIL rr_spacing%0d: %0d cycles between acks, required %0d", i, r.cyc - prev_cyc, exp_lat(1) + 1);
        end
      end
      prev_cyc = r.cyc;
    end
    @(posedge clk);
    #1;
    req = '0;
  endtask

  task automatic test_retry();
    bit found;
    ack_rec_t r;
    int g;
    flush_q();
    script_q.push_back(mk_roll(1'b0, 3'($urandom_range(0, 6))));
    script_q.push_back(mk_roll(1'b0, 3'($urandom_range(0, 6))));
    script_q.push_back(mk_roll(1'b1, 3'd2));
    dreq_cnt = 0;
    @(posedge clk);
    #1;
    req = 4'b0100;
    wait_ack(60, found);
    @(posedge clk);
    #1;
    req = '0;
    checks++;
    if (!found || grant_q.size() == 0) begin
      failures++;
      $display("FAIL retry_timeout: ack seen=%0d, required 1", found);
      return;
    end
    r = ack_q.pop_front();
    g = grant_q.pop_front();
    $display("txn retry ack=%b face=%0d err=%0d lat=%0d", r.ack, r.face, r.err, r.cyc - g);
    checks++;
    if (r.ack !== 4'b0100 || r.face !== 3'd2 || r.err !== 1'b0) begin
      failures++;
      $display("FAIL retry_rsp: ack=%b face=%0d err=%b, required 0100/2/0", r.ack, r.face, r.err);
    end
    checks++;
    if (r.cyc - g != 13) begin
      failures++;
      $display("FAIL retry_lat: %0d cycles, required 13", r.cyc - g);
    end
    checks++;
    if (dreq_cnt != 3) begin
      failures++;
      $display("FAIL retry_dreq: %0d pulses, required 3", dreq_cnt);
    end
  endtask

  task automatic test_exhaust();
    bit found;
    ack_rec_t r;
    int g;
    flush_q();
    for (int i = 0; i <= MAX_RETRY; i++) script_q.push_back(mk_roll(1'b0, 3'($urandom_range(1, 6))));
    dreq_cnt = 0;
    @(posedge clk);
    #1;
    req = 4'b0010;
    wait_ack(100, found);
    @(posedge clk);
    #1;
    req = '0;
    checks++;
    if (!found || grant_q.size() == 0) begin
      failures++;
      $display("FAIL exhaust_timeout: ack seen=%0d, required 1", found);
      return;
    end
    r = ack_q.pop_front();
    g = grant_q.pop_front();
    $display("txn exhaust ack=%b face=%0d err=%0d lat=%0d", r.ack, r.face, r.err, r.cyc - g);
    checks++;
    if (r.ack !== 4'b0010 || r.face !== 3'd0 || r.err !== 1'b1) begin
      failures++;
      $display("FAIL exhaust_rsp: ack=%b face=%0d err=%b, required 0010/0/1", r.ack, r.face, r.err);
    end
    checks++;
    if (r.cyc - g != exp_lat(MAX_RETRY + 1)) begin
      failures++;
      $display("FAIL exhaust_lat: %0d cycles, required %0d", r.cyc - g, exp_lat(MAX_RETRY + 1));
    end
    checks++;
    if (dreq_cnt != MAX_RETRY + 1) begin
      failures++;
      $display("FAIL exhaust_dreq: %0d pulses, required %0d", dreq_cnt, MAX_RETRY + 1);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    ack_rec_t r;
    int g;
    flush_q();
    script_q.push_back(mk_roll(1'b1, 3'd3));
    @(posedge clk);
    #1;
    req = 4'b0001;
    wait_grant(20, found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rstmid_grant: no grant seen, required one");
      req = '0;
      return;
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_busy: busy=%b before reset, required 1", busy);
    end
    rst_n = 1'b0;
    req   = '0;
    #1;
    checks++;
    if ({ack, rsp_face, rsp_err, busy, dice_req} !== 10'd0) begin
      failures++;
      $display("FAIL rstmid_outputs: ack=%b face=%0d err=%b busy=%b dreq=%b, required all 0",
               ack, rsp_face, rsp_err, busy, dice_req);
    end
    repeat (3) @(posedge clk);
    flush_q();
    last_ack_cyc = -100;
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (ack_q.size() != 0) begin
      failures++;
      $display("FAIL rstmid_noack: %0d ack(s) after reset, required 0", ack_q.size());
    end
    ack_q.delete();
    grant_q.delete();
    script_q.push_back(mk_roll(1'b1, 3'd4));
    req = 4'b0001;
    wait_ack(40, found);
    @(posedge clk);
    #1;
    req = '0;
    checks++;
    if (!found || grant_q.size() == 0) begin
      failures++;
      $display("FAIL rstmid_timeout: ack seen=%0d, required 1", found);
      return;
    end
    r = ack_q.pop_front();
    g = grant_q.pop_front();
    $display("txn after_reset ack=%b face=%0d err=%0d lat=%0d", r.ack, r.face, r.err, r.cyc - g);
    checks++;
    if (r.ack !== 4'b0001 || r.face !== 3'd4 || r.err !== 1'b0 || r.cyc - g != exp_lat(1)) begin
      failures++;
      $display("FAIL rstmid_rsp: ack=%b face=%0d err=%b lat=%0d, required 0001/4/0/%0d",
               r.ack, r.face, r.err, r.cyc - g, exp_lat(1));
    end
  endtask

  task automatic test_owner_drop();
    bit found;
    ack_rec_t r;
    flush_q();
    script_q.push_back(mk_roll(1'b1, 3'd6));
    script_q.push_back(mk_roll(1'b1, 3'd1));
    @(posedge clk);
    #1;
    req = 4'b0001;
    wait_grant(20, found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL drop_grant: no grant seen, required one");
      req = '0;
      return;
    end
    @(posedge clk);
    #1;
    req = 4'b0000;
    @(posedge clk);
    #1;
    req = 4'b1000;
    wait_ack(30, found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL drop_timeout1: first ack missing, required one");
      req = '0;
      return;
    end
    r = ack_q.pop_front();
    $display("txn dropped_owner ack=%b face=%0d err=%0d", r.ack, r.face, r.err);
    checks++;
    if (r.ack !== 4'b0001 || r.face !== 3'd6 || r.err !== 1'b0) begin
      failures++;
      $display("FAIL drop_rsp1: ack=%b face=%0d err=%b, required 0001/6/0", r.ack, r.face, r.err);
    end
    wait_ack(30, found);
    @(posedge clk);
    #1;
    req = '0;
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL drop_timeout2: second ack missing, required one");
      return;
    end
    r = ack_q.pop_front();
    $display("txn late_req ack=%b face=%0d err=%0d", r.ack, r.face, r.err);
    checks++;
    if (r.ack !== 4'b1000 || r.face !== 3'd1 || r.err !== 1'b0) begin
      failures++;
      $display("FAIL drop_rsp2: ack=%b face=%0d err=%b, required 1000/1/0", r.ack, r.face, r.err);
    end
  endtask

  task automatic test_random();
    bit found;
    ack_rec_t r;
    int g, model_ptr, owner, rolls, p_inv;
    logic [3:0] pattern;
    logic [2:0] exp_face;
    logic exp_err;
    roll_t roll;
    do_reset();
    model_ptr = 0;
    for (int t = 0; t < 25; t++) begin
      flush_q();
      dreq_cnt = 0;
      pattern = 4'($urandom_range(1, 15));
      case ($urandom_range(0, 2))
        0:       p_inv = 10;
        1:       p_inv = 50;
        default: p_inv = 90;
      endcase
      // Reference: owner is the first requester at or after the pointer.
      owner = -1;
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (pattern[(model_ptr + k) % NREQ]) owner = (model_ptr + k) % NREQ;
      end
      model_ptr = (owner + 1) % NREQ;
      rolls = 0;
      exp_face = 3'd0;
      exp_err = 1'b1;
      for (int j = 0; j <= MAX_RETRY; j++) begin
        roll = mk_roll(($urandom_range(0, 99) >= p_inv), 3'($urandom_range(0, 6)));
        script_q.push_back(roll);
        rolls++;
        if (roll.valid) begin
          exp_face = roll.face;
          exp_err  = 1'b0;
          break;
        end
      end
      @(posedge clk);
      #1;
      req = pattern;
      wait_ack(200, found);
      @(posedge clk);
      #1;
      req = '0;
      checks++;
      if (!found || grant_q.size() == 0) begin
        failures++;
        $display("FAIL rand%0d_timeout: ack seen=%0d, required 1", t, found);
        return;
      end
      r = ack_q.pop_front();
      g = grant_q.pop_front();
      $display("txn rand%0d req=%b ack=%b face=%0d err=%0d lat=%0d rolls=%0d",
               t, pattern, r.ack, r.face, r.err, r.cyc - g, dreq_cnt);
      checks++;
      if (r.ack !== 4'(1 << owner) || r.face !== exp_face || r.err !== exp_err) begin
        failures++;
        $display("FAIL rand%0d_rsp: ack=%b face=%0d err=%b, required %b/%0d/%b",
                 t, r.ack, r.face, r.err, 4'(1 << owner), exp_face, exp_err);
      end
      checks++;
      if (r.cyc - g != exp_lat(rolls) || dreq_cnt != rolls) begin
        failures++;
        $display("FAIL rand%0d_timing: lat=%0d rolls=%0d, required %0d/%0d",
                 t, r.cyc - g, dreq_cnt, exp_lat(rolls), rolls);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_retry();
    test_exhaust();
    test_reset_mid();
    test_owner_drop();
    test_random();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
